retire_trace_ctrl: RTL and testbench
====================================

// Module: retire_trace_ctrl
// PURPOSE
//  Run controller and retire-trace buffer for custom_cpu bring-up on FPGA/sim.
//  - Sequences the CPU reset, watches the global-result word for good/bad trap, and enforces a cycle timeout.
//  - Filters retired register writes from the 70-bit inst_retire bus into a FIFO.
//  - Drains the FIFO to a host/trace sink over a valid/ready stream.
//  - Sits between the CPU core, the memory result word (mem[3]) and the trace consumer.
// PARAMETERS
//  FIFO_DEPTH      16            trace FIFO entries; power of two, >=2
//  TIMEOUT_CYCLES  32'd1000000   RUN cycles before a timeout is declared
//  RESET_HOLD      4             cycles cpu_reset_n is held low after start (>=1)
//  GOOD_VAL        32'h0         result word value meaning good trap
//  BAD_VAL         32'h1         result word value meaning bad trap
// PORTS
//  sys_clk       in   1   clock
//  sys_reset_n   in   1   asynchronous, active-low reset
//  start         in   1   one-cycle pulse; starts a run from IDLE or DONE
//  inst_retire   in   70  [31:0] pc, [63:32] rf_wdata, [68:64] rf_waddr, [69] rf_en
//  result_word   in   32  current value of the global-result memory word
//  cpu_reset_n   out  1   active-low reset driven to the CPU
//  trace_valid   out  1   FIFO head valid
//  trace_ready   in   1   sink accepts head
//  trace_data    out  69  {rf_waddr[4:0], rf_wdata[31:0], pc[31:0]}
//  done          out  1   run finished and FIFO drained
//  status        out  2   00 none, 01 good, 10 bad, 11 timeout
//  retire_cnt    out  32  accepted (pushed or dropped) trace records this run
//  drop_cnt      out  16  records lost to FIFO full; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - State IDLE, FIFO empty, all counters zero.
//  - Outputs cpu_reset_n, trace_valid, done and status are all 0.
//  - Reset mid-run aborts immediately; CPU is forced into reset the same instant.
//  FSM states and transitions:
//  - IDLE:  cpu_reset_n=0; start -> HOLD.
//  - HOLD:  cpu_reset_n=0; count RESET_HOLD cycles -> RUN.
//  - RUN:   cpu_reset_n=1; cycle counter increments.
//           Exit priority: result_word==GOOD_VAL -> DRAIN(01); ==BAD_VAL -> DRAIN(10);
//           counter==TIMEOUT_CYCLES-1 -> DRAIN(11).
//  - DRAIN: cpu_reset_n=0; no new captures; FIFO empty -> DONE.
//  - DONE:  done=1, status held, cpu_reset_n=0; start -> HOLD.
//  - On any entry to HOLD: status, retire_cnt, drop_cnt and the cycle counter are cleared.
//  - start is ignored in HOLD, RUN and DRAIN.
//  Capture:
//  - Push when state==RUN & rf_en & rf_waddr!=0. This includes the cycle trap or timeout is detected.
//  - Records with rf_waddr==0 or rf_en==0 are never counted.
//  - retire_cnt increments per qualifying record and wraps at 2^32.
//  - FIFO full with no pop that cycle: record dropped, drop_cnt += 1 (saturating).
//  - FIFO full with a pop the same cycle: push succeeds, nothing dropped.
//  Stream:
//  - First-word-fall-through. trace_valid = !empty; trace_data = head.
//  - Pop on trace_valid & trace_ready.
//  - A record pushed at edge N appears with trace_valid at N+1 when the FIFO was empty.
//  - trace_data is stable while trace_valid & !trace_ready.
//  - Order is strictly retire order; pointers wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty.
// TESTING
//  1. Reset, then start pulse. Expect: cpu_reset_n low exactly 4 cycles after start, then high; status=00.
//  2. RUN, retire {en=1, waddr=5, wdata=32'hDEADBEEF, pc=32'h0000_0010}, ready=1.
//     Expect: trace_valid next cycle with data {5'd5, DEADBEEF, 00000010}; retire_cnt=1.
//  3. Retire en=1 waddr=0, and en=0 waddr=3.
//     Expect: no push, retire_cnt unchanged.
//  4. ready=0, retire 20 valid records (depth 16).
//     Expect: 16 buffered, drop_cnt=4, retire_cnt=20.
//     Then ready=1: 16 records emerge in pc order.
//  5. result_word=1 with 3 records queued and ready=1.
//     Expect: DRAIN, cpu_reset_n=0; done=1 and status=10 after the 3rd pop.
//     Then start: done=0, counters cleared.
//  6. TIMEOUT_CYCLES=100, result_word held at 32'h5.
//     Expect: status=11 after 100 RUN cycles.
//     Assert sys_reset_n mid-RUN: all outputs 0 immediately.

Source files
------------

// File: rtl/retire_trace_ctrl.sv
// Run controller and retire-trace FIFO for custom_cpu bring-up.
// Sequences CPU reset, detects trap/timeout, and streams filtered register writes to a sink.
module retire_trace_ctrl #(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
    parameter int unsigned RESET_HOLD     = 4,
    parameter logic [31:0] GOOD_VAL       = 32'h0,
    parameter logic [31:0] BAD_VAL        = 32'h1
) (
    input  logic        sys_clk,
    input  logic        sys_reset_n,
    input  logic        start,
    input  logic [69:0] inst_retire,
    input  logic [31:0] result_word,
    output logic        cpu_reset_n,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [68:0] trace_data,
    output logic        done,
    output logic [1:0]  status,
    output logic [31:0] retire_cnt,
    output logic [15:0] drop_cnt
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [31:0] HoldLast = 32'(RESET_HOLD - 1);
    localparam logic [31:0] TimeLast = TIMEOUT_CYCLES - 32'd1;

    typedef enum logic [2:0] {StIdle, StHold, StRun, StDrain, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  status_q, status_d;
    logic [31:0] retire_cnt_q;
    logic [15:0] drop_cnt_q;
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [68:0] mem_q [FIFO_DEPTH];

    logic empty, full, pop, push_req, push, drop, clr;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop      = !empty && trace_ready;
    assign push_req = (state_q == StRun) && inst_retire[69] && (inst_retire[68:64] != 5'd0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign clr      = start && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StHold;
                    cnt_d    = 32'd0;
                    status_d = 2'b00;
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d = StRun;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 32'd1;
                if (result_word == GOOD_VAL) begin
                    state_d  = StDrain;
                    status_d = 2'b01;
                end else if (result_word == BAD_VAL) begin
                    state_d  = StDrain;
                    status_d = 2'b10;
                end else if (cnt_q == TimeLast) begin
                    state_d  = StDrain;
                    status_d = 2'b11;
                end
            end
            StDrain: begin
                if (empty) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    state_d  = StHold;
                    cnt_d    = 32'd0;
                    status_d = 2'b00;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= 32'd0;
            status_q     <= 2'b00;
            retire_cnt_q <= 32'd0;
            drop_cnt_q   <= 16'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            if (clr) begin
                retire_cnt_q <= 32'd0;
                drop_cnt_q   <= 16'd0;
            end else begin
                if (push_req) begin
                    retire_cnt_q <= retire_cnt_q + 32'd1;
                end
                if (drop && (drop_cnt_q != 16'hFFFF)) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {inst_retire[68:64], inst_retire[63:32], inst_retire[31:0]};
        end
    end

    // Outputs decode directly from state so an async reset takes effect at once.
    assign cpu_reset_n = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign status      = status_q;
    assign trace_valid = !empty;
    assign trace_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign retire_cnt  = retire_cnt_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_retire_trace_ctrl.sv
// Directed bench for retire_trace_ctrl: vector table for capture filtering plus
// hand-written sequences for FIFO overflow, trap drain, timeout and async reset.
module tb_retire_trace_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_reset_n;
    logic        start;
    logic [69:0] inst_retire;
    logic [31:0] result_word;
    logic        cpu_reset_n;
    logic        trace_valid;
    logic        trace_ready;
    logic [68:0] trace_data;
    logic        done;
    logic [1:0]  status;
    logic [31:0] retire_cnt;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    retire_trace_ctrl #(
        .FIFO_DEPTH     (16),
        .TIMEOUT_CYCLES (32'd100),
        .RESET_HOLD     (4),
        .GOOD_VAL       (32'h0),
        .BAD_VAL        (32'h1)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .start       (start),
        .inst_retire (inst_retire),
        .result_word (result_word),
        .cpu_reset_n (cpu_reset_n),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_data  (trace_data),
        .done        (done),
        .status      (status),
        .retire_cnt  (retire_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        en;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        exp_valid;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    // Record i of the overflow burst: {waddr, wdata, pc}
    function automatic logic [68:0] rec(input int i);
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
        wa = 5'((i % 31) + 1);
        wd = 32'hC0DE_0000 + 32'(i);
        pc = 32'h0000_0100 + 32'(4 * i);
        return {wa, wd, pc};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int run_cycles;

        vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 32'd1};
        vecs[1] = '{1'b1, 5'd0,  32'h1111_1111, 32'h0000_0020, 1'b0, 32'd1};
        vecs[2] = '{1'b0, 5'd3,  32'h2222_2222, 32'h0000_0024, 1'b0, 32'd1};
        vecs[3] = '{1'b1, 5'd31, 32'h1234_5678, 32'h0000_0014, 1'b1, 32'd2};
        vecs[4] = '{1'b1, 5'd1,  32'hA5A5_A5A5, 32'h0000_0018, 1'b1, 32'd3};
        vecs[5] = '{1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 32'd3};

        sys_reset_n = 1'b0;
        start       = 1'b0;
        inst_retire = '0;
        result_word = 32'h5;
        trace_ready = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_reset_n = 1'b1;
        step();

        chk("rst_cpu_reset_n", 69'(cpu_reset_n), 69'd0);
        chk("rst_trace_valid", 69'(trace_valid), 69'd0);
        chk("rst_done", 69'(done), 69'd0);
        chk("rst_status", 69'(status), 69'd0);
        chk("rst_retire_cnt", 69'(retire_cnt), 69'd0);
        chk("rst_drop_cnt", 69'(drop_cnt), 69'd0);

        // CPU reset held low for exactly 4 cycles after start.
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk("hold_cpu_reset_low", 69'(cpu_reset_n), 69'd0);
            step();
        end
        chk("run_cpu_reset_high", 69'(cpu_reset_n), 69'd1);
        chk("run_status", 69'(status), 69'd0);

        // Capture filtering, ready held high so each record pops one cycle later.
        for (int v = 0; v < 6; v++) begin
            inst_retire = {vecs[v].en, vecs[v].wa, vecs[v].wd, vecs[v].pc};
            step();
            chk($sformatf("vec%0d_valid", v), 69'(trace_valid), 69'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                chk($sformatf("vec%0d_data", v), trace_data, {vecs[v].wa, vecs[v].wd, vecs[v].pc});
            end
            chk($sformatf("vec%0d_retire_cnt", v), 69'(retire_cnt), 69'(vecs[v].exp_cnt));
        end
        inst_retire = '0;

        // Overflow: 20 records into a 16-deep FIFO with the sink stalled.
        trace_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            inst_retire = {1'b1, rec(i)};
            step();
        end
        inst_retire = '0;
        step();
        chk("ovf_drop_cnt", 69'(drop_cnt), 69'd4);
        chk("ovf_retire_cnt", 69'(retire_cnt), 69'd23);
        chk("ovf_valid", 69'(trace_valid), 69'd1);
        chk("ovf_head_stable", trace_data, rec(0));

        // Push into a full FIFO with a simultaneous pop: nothing dropped.
        trace_ready = 1'b1;
        inst_retire = {1'b1, rec(20)};
        step();
        inst_retire = '0;
        chk("fullpop_drop_cnt", 69'(drop_cnt), 69'd4);
        chk("fullpop_retire_cnt", 69'(retire_cnt), 69'd24);
        for (int k = 1; k < 16; k++) begin
            chk($sformatf("drain_rec%0d", k), trace_data, rec(k));
            step();
        end
        chk("drain_rec20", trace_data, rec(20));
        step();
        chk("drain_empty", 69'(trace_valid), 69'd0);

        // Bad trap with 3 records queued.
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inst_retire = {1'b1, 5'd7, 32'hBAD0_0000 + 32'(i), 32'h0000_0200 + 32'(4 * i)};
            step();
        end
        inst_retire = '0;
        result_word = 32'h1;
        trace_ready = 1'b1;
        step();
        chk("trap_cpu_reset_low", 69'(cpu_reset_n), 69'd0);
        chk("trap_head1", trace_data, {5'd7, 32'hBAD0_0001, 32'h0000_0204});
        chk("trap_not_done", 69'(done), 69'd0);
        step();
        chk("trap_head2", trace_data, {5'd7, 32'hBAD0_0002, 32'h0000_0208});
        for (int i = 0; i < 10 && !done; i++) step();
        chk("trap_done", 69'(done), 69'd1);
        chk("trap_status", 69'(status), 69'd2);
        chk("trap_fifo_empty", 69'(trace_valid), 69'd0);
        chk("trap_retire_cnt", 69'(retire_cnt), 69'd27);
        step();
        chk("done_held", 69'(done), 69'd1);

        // Restart clears counters and status.
        result_word = 32'h5;
        pulse_start();
        chk("restart_done", 69'(done), 69'd0);
        chk("restart_status", 69'(status), 69'd0);
        chk("restart_retire_cnt", 69'(retire_cnt), 69'd0);
        chk("restart_drop_cnt", 69'(drop_cnt), 69'd4 - 69'd4);
        chk("restart_cpu_reset", 69'(cpu_reset_n), 69'd0);

        // Timeout after exactly 100 RUN cycles.
        run_cycles = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (cpu_reset_n) run_cycles++;
            step();
        end
        chk("timeout_done", 69'(done), 69'd1);
        chk("timeout_run_cycles", 69'(run_cycles), 69'd100);
        chk("timeout_status", 69'(status), 69'd3);

        // Async reset mid-run.
        pulse_start();
        repeat (4) step();
        chk("rerun_cpu_reset_high", 69'(cpu_reset_n), 69'd1);
        trace_ready = 1'b0;
        inst_retire = {1'b1, 5'd9, 32'h0000_00AA, 32'h0000_0300};
        step();
        inst_retire = '0;
        chk("rerun_valid", 69'(trace_valid), 69'd1);
        chk("rerun_retire_cnt", 69'(retire_cnt), 69'd1);
        #2;
        sys_reset_n = 1'b0;
        #1;
        chk("arst_cpu_reset_n", 69'(cpu_reset_n), 69'd0);
        chk("arst_trace_valid", 69'(trace_valid), 69'd0);
        chk("arst_done", 69'(done), 69'd0);
        chk("arst_status", 69'(status), 69'd0);
        chk("arst_retire_cnt", 69'(retire_cnt), 69'd0);
        chk("arst_drop_cnt", 69'(drop_cnt), 69'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
